// File: rtl/xadc_drp_scheduler.sv
// xadc_drp_scheduler: round-robin XADC DRP reader for up to four channels, with
// one-deep eoc queueing, overflow counting and drdy timeout detection.
`default_nettype none

module xadc_drp_scheduler #(
  parameter logic [6:0] ADDR0   = 7'h11,
  parameter logic [6:0] ADDR1   = 7'h10,
  parameter logic [6:0] ADDR2   = 7'h18,
  parameter logic [6:0] ADDR3   = 7'h19,
  parameter int         TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        eoc,
  input  logic        drdy,
  input  logic [15:0] do_in,
  input  logic [3:0]  ch_en,
  output logic        den,
  output logic [6:0]  daddr,
  output logic        dwe,
  output logic [15:0] ch0_data,
  output logic [15:0] ch1_data,
  output logic [15:0] ch2_data,
  output logic [15:0] ch3_data,
  output logic        data_valid,
  output logic [1:0]  data_ch,
  output logic [7:0]  ovf_cnt,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic        eoc_q;
  logic        pending;
  logic [1:0]  last_ch;
  logic [1:0]  cur_ch;
  logic [7:0]  wait_cnt;
  logic [15:0] ch_data [4];

  logic        start, capture, expire;
  logic [1:0]  sel_ch, cand;
  logic [6:0]  sel_addr;

  // Lowest offset from last_ch wins; last_ch itself is the fallback when only it is enabled.
  always_comb begin
    sel_ch = last_ch;
    cand   = last_ch;
    for (int k = 3; k >= 1; k--) begin
      cand = last_ch + 2'(k);
      if (ch_en[cand]) sel_ch = cand;
    end
  end

  always_comb begin
    sel_addr = ADDR0;
    case (sel_ch)
      2'd0:    sel_addr = ADDR0;
      2'd1:    sel_addr = ADDR1;
      2'd2:    sel_addr = ADDR2;
      default: sel_addr = ADDR3;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    capture   = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: begin
        if ((eoc_q || pending) && (ch_en != 4'd0)) begin
          start     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (drdy) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end else if (wait_cnt == TMO_LAST) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eoc_q       <= 1'b0;
      pending     <= 1'b0;
      last_ch     <= 2'd3;
      cur_ch      <= 2'd0;
      wait_cnt    <= 8'd0;
      den         <= 1'b0;
      daddr       <= ADDR0;
      data_valid  <= 1'b0;
      data_ch     <= 2'd0;
      ovf_cnt     <= 8'd0;
      timeout_err <= 1'b0;
      for (int i = 0; i < 4; i++) ch_data[i] <= 16'd0;
    end else begin
      eoc_q      <= eoc;
      den        <= start;
      data_valid <= capture;
      wait_cnt   <= (state == WAIT && !capture && !expire) ? wait_cnt + 8'd1 : 8'd0;
      if (start) begin
        cur_ch  <= sel_ch;
        last_ch <= sel_ch;
        daddr   <= sel_addr;
      end
      if (capture) begin
        ch_data[cur_ch] <= do_in;
        data_ch         <= cur_ch;
      end
      if (expire) timeout_err <= 1'b1;
      // An eoc landing on the completing WAIT cycle is queued rather than counted as lost.
      if (start) begin
        pending <= 1'b0;
      end else if (eoc_q && state != IDLE) begin
        if (capture || expire || !pending) pending <= 1'b1;
        else if (ovf_cnt != 8'hFF)         ovf_cnt <= ovf_cnt + 8'd1;
      end
    end
  end

  assign dwe      = 1'b0;
  assign ch0_data = ch_data[0];
  assign ch1_data = ch_data[1];
  assign ch2_data = ch_data[2];
  assign ch3_data = ch_data[3];

endmodule

`default_nettype wire

// File: doc/xadc_drp_scheduler.md
XADC_DRP_SCHEDULER -- requirements
Module: xadc_drp_scheduler

Interface
REQ-001 Parameter ADDR0, default 7'h11, DRP address of logical channel 0.
REQ-002 Parameter ADDR1, default 7'h10, DRP address of logical channel 1.
REQ-003 Parameter ADDR2, default 7'h18, DRP address of logical channel 2.
REQ-004 Parameter ADDR3, default 7'h19, DRP address of logical channel 3.
REQ-005 Parameter TIMEOUT, default 255, maximum cycles spent in WAIT for drdy (range 1..255).
REQ-006 clk  in  1  system clock (100 MHz); all state changes on its rising edge.
REQ-007 rst  in  1  asynchronous, active-high reset.
REQ-008 eoc  in  1  XADC end-of-conversion pulse; sampled synchronously.
REQ-009 drdy  in  1  XADC DRP data-ready pulse.
REQ-010 do_in  in  16  XADC DRP read data.
REQ-011 ch_en  in  4  per-channel enable mask; bit i enables logical channel i.
REQ-012 den  out  1  DRP enable, single-cycle pulse.
REQ-013 daddr  out  7  DRP address.
REQ-014 dwe  out  1  DRP write enable, constant 0.
REQ-015 ch0_data..ch3_data  out  16 each  last captured sample per channel.
REQ-016 data_valid  out  1  one-cycle pulse on each capture.
REQ-017 data_ch  out  2  logical channel of the most recent capture.
REQ-018 ovf_cnt  out  8  saturating count of dropped eoc events.
REQ-019 timeout_err  out  1  sticky flag, set on drdy timeout.

Function
REQ-020 The FSM SHALL have states IDLE, ISSUE, WAIT; all outputs registered.
REQ-021 IDLE: if (eoc or pending) and ch_en!=0, select channel and go to ISSUE; clear pending.
REQ-022 Selection SHALL be round-robin: first enabled channel after last_ch, modulo 4, searching last_ch+1, +2, +3, then last_ch itself.
REQ-023 ISSUE: den=1 for exactly one cycle, daddr=ADDRn of the selected channel; last_ch updated to selected; next state WAIT.
REQ-024 Latency: eoc sampled high in IDLE at edge N -> den high in the cycle after edge N+1 (one ISSUE cycle), WAIT from edge N+2.
REQ-025 daddr SHALL hold its last issued value outside ISSUE.
REQ-026 WAIT: on drdy, load do_in into chN_data, set data_ch=N, pulse data_valid one cycle, go to IDLE.
REQ-027 WAIT: an 8-bit counter SHALL count cycles without drdy; reaching TIMEOUT sets timeout_err, returns to IDLE, no data register or data_valid change.
REQ-028 drdy outside WAIT SHALL be ignored.
REQ-029 eoc while in ISSUE or WAIT SHALL set a one-deep pending flag; eoc while pending is already set increments ovf_cnt, saturating at 255.
REQ-030 eoc arriving in the same cycle WAIT completes (drdy or timeout) SHALL set pending, not count overflow.
REQ-031 eoc with ch_en==0 in IDLE SHALL be discarded: no pending, no ovf_cnt change.
REQ-032 ch_en changes take effect at the next selection only; an in-flight read completes.
REQ-033 timeout_err clears only on rst.

Reset
REQ-034 rst SHALL force, asynchronously: state IDLE, den=0, dwe=0, daddr=ADDR0, all chN_data=0, data_valid=0, data_ch=0, ovf_cnt=0, timeout_err=0, pending=0, timeout counter=0, last_ch=3 (so first selection is channel 0).
REQ-035 rst asserted in WAIT SHALL abort the read; a later drdy SHALL not update any data register.

Verification
REQ-036 ch_en=4'hF, four eoc pulses 20 cycles apart, drdy 4 cycles after each den, do_in=16'h1000+i -> daddr 7'h11,7'h10,7'h18,7'h19 in order; ch0..ch3_data=16'h1000..16'h1003; four data_valid pulses.
REQ-037 ch_en=4'b0101, three eoc -> channels 0,2,0 selected; ch1/ch3 data stay 0.
REQ-038 eoc, then two more eoc during WAIT -> one pending read issued after capture; ovf_cnt=1.
REQ-039 TIMEOUT=10, eoc, no drdy -> IDLE after 10 WAIT cycles; timeout_err=1; data_valid never pulses; next eoc issues the next round-robin channel.
REQ-040 rst pulse mid-WAIT, then drdy with do_in=16'hABCD -> all data registers 0, no data_valid; next eoc issues daddr 7'h11.
REQ-041 ch_en=0, 300 eoc pulses -> den never asserts; ovf_cnt stays 0; separately, 300 overflowing eoc with drdy withheld -> ovf_cnt saturates at 255.
